// File: rtl/prbs_pattern_tx.sv
// rtl/prbs_pattern_tx.sv - serial sync-pattern then PRBS-15 transmit source
//
// Purpose: on start, sends the 32-bit sync frame n times back-to-back
// (byte PATTERN[31:24] first, each byte LSB first), then switches without a
// gap to a free-running PRBS-15 (x^15+x^14+1) stream until stop.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   begin transmission (accepted only in IDLE)
//   stop       in   end the PRBS phase (sampled only in PRBS)
//   n[2:0]     in   number of sync frames, latched on accepted start
//   err_inj    in   invert the bit being registered (PRBS_TX_ERR_INJ_EN only)
//   data_out   out  registered serial bit, 0 whenever data_valid is low
//   data_valid out  data_out carries a pattern or PRBS bit
//   busy       out  transmission in progress (aligned with data_valid)
//   pat_done   out  one-cycle pulse alongside the last pattern bit
//
// Optional feature macro: PRBS_TX_ERR_INJ_EN (adds err_inj input).

module prbs_pattern_tx #(
  parameter logic [31:0] PATTERN = 32'hABCDEF01,
  parameter logic [14:0] SEED    = 15'h7FFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] n,
`ifdef PRBS_TX_ERR_INJ_EN
  input  logic       err_inj,
`endif
  output logic       data_out,
  output logic       data_valid,
  output logic       busy,
  output logic       pat_done
);

  // An all-zero seed would lock the LFSR, so it is replaced.
  localparam logic [14:0] SEED_EFF = (SEED == 15'd0) ? 15'h7FFF : SEED;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PATTERN = 2'd1,
    S_PRBS    = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  n_lat, n_lat_nxt;
  logic [4:0]  bit_cnt, bit_cnt_nxt;
  logic [2:0]  frame_cnt, frame_cnt_nxt;
  logic [14:0] lfsr, lfsr_nxt;
  logic        data_out_nxt;
  logic        data_valid_nxt;
  logic        busy_nxt;
  logic        pat_done_nxt;
  logic        tx_en;
  logic        tx_bit;
  logic        inj;

`ifdef PRBS_TX_ERR_INJ_EN
  assign inj = err_inj;
`else
  assign inj = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      n_lat      <= 3'd0;
      bit_cnt    <= 5'd0;
      frame_cnt  <= 3'd0;
      lfsr       <= SEED_EFF;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      pat_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      n_lat      <= n_lat_nxt;
      bit_cnt    <= bit_cnt_nxt;
      frame_cnt  <= frame_cnt_nxt;
      lfsr       <= lfsr_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      busy       <= busy_nxt;
      pat_done   <= pat_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    n_lat_nxt     = n_lat;
    bit_cnt_nxt   = bit_cnt;
    frame_cnt_nxt = frame_cnt;
    lfsr_nxt      = lfsr;
    pat_done_nxt  = 1'b0;
    tx_en         = 1'b0;
    tx_bit        = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          n_lat_nxt     = n;
          bit_cnt_nxt   = 5'd0;
          frame_cnt_nxt = 3'd0;
          lfsr_nxt      = SEED_EFF;
          state_nxt     = (n != 3'd0) ? S_PATTERN : S_PRBS;
        end
      end

      S_PATTERN: begin
        tx_en = 1'b1;
        // Byte (3 - bit_cnt[4:3]) first from the MSB end, bit bit_cnt[2:0]
        // within it; 3 - x on two bits is simply ~x.
        tx_bit      = PATTERN[{~bit_cnt[4:3], bit_cnt[2:0]}];
        bit_cnt_nxt = bit_cnt + 5'd1;
        if (bit_cnt == 5'd31) begin
          frame_cnt_nxt = frame_cnt + 3'd1;
          if (frame_cnt == n_lat - 3'd1) begin
            state_nxt    = S_PRBS;
            pat_done_nxt = 1'b1;
          end
        end
      end

      S_PRBS: begin
        tx_en    = 1'b1;
        tx_bit   = lfsr[14];
        lfsr_nxt = {lfsr[13:0], lfsr[14] ^ lfsr[13]};
        if (stop) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Outputs lag the state by one register stage; data_out is held at 0
    // whenever no bit is being sent.
    data_valid_nxt = tx_en;
    busy_nxt       = tx_en;
    data_out_nxt   = tx_en & (tx_bit ^ inj);
  end

endmodule

// File: doc/prbs_pattern_tx.md
# prbs_pattern_tx

- Serial transmit source for the PRBS-15 link; drives the serial stream that the pattern detector consumes.
- On `start`, sends a 32-bit sync pattern `n` times back-to-back, one bit per clock, then switches seamlessly to a free-running PRBS-15 sequence until `stop`.
- Sits at the transmit end of the link and feeds the detector's `data` input directly.

## Interface
- `PATTERN`, 32'hABCDEF01: sync frame. Byte `PATTERN[31:24]` is sent first; each byte is sent LSB first.
- `SEED`, 15'h7FFF: LFSR load value. A value of 0 is replaced by 15'h7FFF.
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a transmission; sampled only in IDLE.
- `stop`  in  1  ends the PRBS phase; sampled only in PRBS.
- `n`  in  3  number of pattern frames (0–7); latched on accepted `start`.
- `data_out`  out  1  serial bit, registered.
- `data_valid`  out  1  high while `data_out` carries a pattern or PRBS bit.
- `busy`  out  1  high in PATTERN and PRBS states.
- `pat_done`  out  1  one-cycle pulse when the last pattern bit is on `data_out`.
- `err_inj`  in  1  only when `PRBS_TX_ERR_INJ_EN` is defined; see Configuration.

## Operation
- FSM states: IDLE, PATTERN, PRBS.
- IDLE
  - On `start`: latch `n`, clear `bit_cnt` (5 bits) and `frame_cnt` (3 bits), load `lfsr` with `SEED`.
  - Go to PATTERN if `n` ≠ 0, otherwise go to PRBS.
- PATTERN
  - Each cycle emits bit `PATTERN[8*(3-bit_cnt[4:3]) + bit_cnt[2:0]]`, then increments `bit_cnt`.
  - When `bit_cnt` = 31, `bit_cnt` wraps to 0 and `frame_cnt` increments.
  - When `bit_cnt` = 31 and `frame_cnt` = `n_latched`-1, go to PRBS; `pat_done` is high with that last bit.
  - `start` and `stop` are ignored in this state.
- PRBS
  - Polynomial x^15+x^14+1.
  - Emits `lfsr[14]`, then updates `lfsr` ← {`lfsr[13:0]`, `lfsr[14]^lfsr[13]`}.
  - `lfsr` advances only in this state.
  - On `stop`: go to IDLE; the bit emitted in the `stop` cycle is the last valid bit.
- Other rules
  - `start` while busy is ignored.
  - An unreachable state encoding returns to IDLE.
  - `rst` at any cycle, including mid-frame: all registers return to reset values at that edge; the frame is abandoned with no partial-frame recovery.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `busy`=0, `pat_done`=0, `lfsr`=`SEED`, state=IDLE.
- Latency: `start` sampled at edge k; first bit on `data_out`, with `data_valid`=1, after edge k+1.
- Pattern phase length is exactly 32·n cycles with no gaps.
- First PRBS bit follows the last pattern bit on the next cycle. It equals `SEED[14]`.
- `stop` sampled at edge m → `data_valid`=0 and `busy`=0 after edge m+1.
- A new `start` is accepted no earlier than edge m+1.
- While `data_valid`=0, `data_out` is forced to 0.

## Configuration
- `PRBS_TX_ERR_INJ_EN` defined
  - Adds input `err_inj`. When `err_inj`=1 in a cycle where a bit is being registered, that bit is inverted on `data_out`.
  - Valid in both phases; the LFSR sequence itself is not altered.
  - Used to exercise detector rejection.
- Undefined: the port and the inversion logic are absent; the output is always the clean stream.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles, `start`=0 → `data_out`=0, `data_valid`=0, `busy`=0 for 20 cycles.
- n=1, default `PATTERN`, `start` pulse → first 8 bits 1,1,0,1,0,1,0,1 (0xAB LSB first).
  - Then 0xCD, 0xEF, 0x01 follow; `pat_done` pulses in cycle 32.
  - First PRBS bit in cycle 33 = 1.
- n=3 → 96 pattern bits (three identical frames), `pat_done` pulses once at bit 96, PRBS follows.
  - 32767-cycle capture of the PRBS phase repeats exactly with period 32767 and contains 16384 ones.
- n=0 → PRBS starts at the first valid bit. `start` pulses during busy are ignored.
  - `stop` at PRBS bit 100 → `data_valid` falls on the next cycle; `start` again reproduces the identical sequence from `SEED`.
- `rst` asserted at pattern bit 17 of frame 2 (n=5) → idle outputs on the next cycle; a new `start` restarts from frame 0 bit 0.
- With `PRBS_TX_ERR_INJ_EN`: `err_inj` high for pattern bit 0 → first bit is 0; all other bits match the clean run.
